// File: rtl/stl_req_queue_if.sv
// Handshake bundle between the request producers, the per-channel request
// queues and the downstream arbiter.
interface stl_req_queue_if #(
  parameter int REQ_N = 8,
  parameter int DAT_W = 16,
  parameter int DEPTH = 4,
  parameter int WGT_W = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [REQ_N-1:0]            in_vld_i;
  logic [REQ_N-1:0][DAT_W-1:0] in_dat_i;
  logic [REQ_N-1:0]            in_rdy_o;
  logic [REQ_N-1:0]            req_vld_o;
  logic [REQ_N-1:0][DAT_W-1:0] req_dat_o;
  logic [REQ_N-1:0][WGT_W-1:0] req_wgt_o;
  logic [REQ_N-1:0]            req_rdy_i;
  logic [REQ_N-1:0][OCC_W-1:0] occ_o;

  // Producer/arbiter side.
  modport master (
    output in_vld_i, in_dat_i, req_rdy_i,
    input  in_rdy_o, req_vld_o, req_dat_o, req_wgt_o, occ_o
  );

  // Queue side.
  modport slave (
    input  in_vld_i, in_dat_i, req_rdy_i,
    output in_rdy_o, req_vld_o, req_dat_o, req_wgt_o, occ_o
  );
endinterface

// File: rtl/stl_req_queue.sv
// Per-channel request FIFOs feeding an arbiter, with an age counter per head
// entry that is exported as a saturating urgency weight.
module stl_req_queue #(
  parameter int REQ_N  = 8,
  parameter int DAT_W  = 16,
  parameter int DEPTH  = 4,
  parameter int WGT_W  = 2,
  parameter int AGE_SH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  stl_req_queue_if.slave bus
);
  localparam int AGE_W = WGT_W + AGE_SH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  genvar gi;
  generate
    for (gi = 0; gi < REQ_N; gi++) begin : g_chan
      logic [DAT_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [OCC_W-1:0] occ_reg;
      logic [AGE_W-1:0] age_reg;
      logic             rdy;
      logic             vld;
      logic             push;
      logic             pop;

      // Flush blocks both directions so nothing presented during it survives.
      always_comb begin
        rdy  = (occ_reg != OCC_FULL) && !flush_i;
        vld  = (occ_reg != '0);
        push = bus.in_vld_i[gi] && rdy;
        pop  = vld && bus.req_rdy_i[gi] && !flush_i;
      end

      always_ff @(posedge clk) begin
        if (push && !rst) begin
          mem[wr_ptr_reg] <= bus.in_dat_i[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          occ_reg    <= '0;
          age_reg    <= '0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end
          case ({push, pop})
            2'b10:   occ_reg <= occ_reg + OCC_W'(1);
            2'b01:   occ_reg <= occ_reg - OCC_W'(1);
            default: occ_reg <= occ_reg;
          endcase
          // Age tracks how long the current head has been refused.
          if (pop || !vld) begin
            age_reg <= '0;
          end else if (!bus.req_rdy_i[gi] && (age_reg != AGE_MAX)) begin
            age_reg <= age_reg + AGE_W'(1);
          end
        end
      end

      assign bus.in_rdy_o[gi]  = rdy;
      assign bus.req_vld_o[gi] = vld;
      assign bus.req_dat_o[gi] = mem[rd_ptr_reg];
      assign bus.req_wgt_o[gi] = age_reg[AGE_W-1:AGE_SH];
      assign bus.occ_o[gi]     = occ_reg;
    end
  endgenerate
endmodule

// File: tb/tb_stl_req_queue.sv
// Randomized and directed checks of stl_req_queue against a queue-based model.
module tb_stl_req_queue;
  localparam int N    = 8;
  localparam int DW   = 16;
  localparam int D    = 4;
  localparam int WW   = 2;
  localparam int SH   = 2;
  localparam int AW   = WW + SH;
  localparam int OW   = $clog2(D + 1);
  localparam int AMAX = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  stl_req_queue_if #(.REQ_N(N), .DAT_W(DW), .DEPTH(D), .WGT_W(WW)) bus ();

  stl_req_queue #(.REQ_N(N), .DAT_W(DW), .DEPTH(D), .WGT_W(WW), .AGE_SH(SH)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one queue of payloads and one head age per channel.
  logic [DW-1:0] mq [N][$];
  int            mage [N];

  // Apply current inputs across one clock edge and advance the model.
  task automatic tick();
    bit            push [N];
    bit            pop  [N];
    bit            v    [N];
    bit            stall [N];
    logic [DW-1:0] d    [N];
    for (int c = 0; c < N; c++) begin
      v[c]     = (mq[c].size() != 0);
      push[c]  = bus.in_vld_i[c] && (mq[c].size() != D) && !flush;
      pop[c]   = v[c] && bus.req_rdy_i[c] && !flush;
      stall[c] = !bus.req_rdy_i[c];
      d[c]     = bus.in_dat_i[c];
    end
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      if (rst || flush) begin
        mq[c].delete();
        mage[c] = 0;
      end else begin
        if (pop[c]) void'(mq[c].pop_front());
        if (push[c]) mq[c].push_back(d[c]);
        if (pop[c] || !v[c]) mage[c] = 0;
        else if (stall[c]) mage[c] = (mage[c] + 1 > AMAX) ? AMAX : mage[c] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    if (bus.req_vld_o !== '0) begin
      fails++; $display("FAIL reset_vld: got %h expected 0", bus.req_vld_o);
    end
    tests++;
    if (bus.occ_o !== '0) begin
      fails++; $display("FAIL reset_occ: got %h expected 0", bus.occ_o);
    end
    tests++;
    if (bus.req_wgt_o !== '0) begin
      fails++; $display("FAIL reset_wgt: got %h expected 0", bus.req_wgt_o);
    end
    tests++;
    if (bus.in_rdy_o !== {N{1'b1}}) begin
      fails++; $display("FAIL reset_rdy: got %h expected all ones", bus.in_rdy_o);
    end
    tests++;
    $display("[TB] reset done");
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] fd [4];
    fd[0] = 16'h0011; fd[1] = 16'h0022; fd[2] = 16'h0033; fd[3] = 16'h0044;
    for (int i = 0; i < 4; i++) begin
      bus.in_vld_i[0] = 1'b1;
      bus.in_dat_i[0] = fd[i];
      tick();
    end
    bus.in_vld_i[0] = 1'b0;
    #1;
    if (bus.occ_o[0] !== OW'(4)) begin
      fails++; $display("FAIL fill_occ: got %0d expected 4", bus.occ_o[0]);
    end
    tests++;
    if (bus.in_rdy_o[0] !== 1'b0) begin
      fails++; $display("FAIL fill_rdy: got %b expected 0", bus.in_rdy_o[0]);
    end
    tests++;
    bus.req_rdy_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.req_vld_o[0] !== 1'b1 || bus.req_dat_o[0] !== fd[i]) begin
        fails++;
        $display("FAIL drain_dat%0d: got vld=%b dat=%h expected vld=1 dat=%h",
                 i, bus.req_vld_o[0], bus.req_dat_o[0], fd[i]);
      end
      tests++;
      tick();
    end
    bus.req_rdy_i[0] = 1'b0;
    #1;
    if (bus.occ_o[0] !== '0 || bus.req_vld_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: got occ=%0d vld=%b expected occ=0 vld=0",
               bus.occ_o[0], bus.req_vld_o[0]);
    end
    tests++;
    $display("[TB] fill/drain ch0 done");
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] v [4];
    for (int i = 0; i < 4; i++) begin
      v[i] = DW'($urandom);
      bus.in_vld_i[1] = 1'b1;
      bus.in_dat_i[1] = v[i];
      tick();
    end
    bus.in_dat_i[1] = 16'hBEEF;
    bus.req_rdy_i[1] = 1'b1;
    #1;
    if (bus.in_rdy_o[1] !== 1'b0) begin
      fails++; $display("FAIL full_rdy: got %b expected 0", bus.in_rdy_o[1]);
    end
    tests++;
    tick();
    bus.in_vld_i[1] = 1'b0;
    #1;
    if (bus.occ_o[1] !== OW'(3) || bus.req_dat_o[1] !== v[1]) begin
      fails++;
      $display("FAIL full_pop: got occ=%0d dat=%h expected occ=3 dat=%h",
               bus.occ_o[1], bus.req_dat_o[1], v[1]);
    end
    tests++;
    for (int i = 0; i < 3; i++) tick();
    bus.req_rdy_i[1] = 1'b0;
    #1;
    if (bus.occ_o[1] !== '0) begin
      fails++; $display("FAIL full_drain: got occ=%0d expected 0", bus.occ_o[1]);
    end
    tests++;
    $display("[TB] full with simultaneous pop ch1 done");
  endtask

  task automatic test_aging();
    logic [DW-1:0] a = 16'hA0A0;
    logic [DW-1:0] b = 16'hB0B0;
    int            k_sat;
    bus.in_vld_i[3] = 1'b1;
    bus.in_dat_i[3] = a;
    tick();
    for (int k = 0; k < 18; k++) begin
      bus.in_vld_i[3] = (k == 0);
      bus.in_dat_i[3] = b;
      #1;
      k_sat = (k > 15) ? 15 : k;
      if (bus.req_wgt_o[3] !== WW'(k_sat >> 2)) begin
        fails++;
        $display("FAIL age_wgt_k%0d: got %0d expected %0d", k, bus.req_wgt_o[3], k_sat >> 2);
      end
      tests++;
      tick();
    end
    bus.in_vld_i[3] = 1'b0;
    bus.req_rdy_i[3] = 1'b1;
    tick();
    bus.req_rdy_i[3] = 1'b0;
    #1;
    if (bus.req_wgt_o[3] !== '0 || bus.req_vld_o[3] !== 1'b1 || bus.req_dat_o[3] !== b) begin
      fails++;
      $display("FAIL age_next_head: got wgt=%0d vld=%b dat=%h expected wgt=0 vld=1 dat=%h",
               bus.req_wgt_o[3], bus.req_vld_o[3], bus.req_dat_o[3], b);
    end
    tests++;
    bus.req_rdy_i[3] = 1'b1;
    tick();
    bus.req_rdy_i[3] = 1'b0;
    $display("[TB] aging ch3 done");
  endtask

  task automatic test_push_pop_wrap();
    logic [DW-1:0] ex [$];
    logic [DW-1:0] nd;
    for (int i = 0; i < 2; i++) begin
      nd = DW'($urandom);
      bus.in_vld_i[2] = 1'b1;
      bus.in_dat_i[2] = nd;
      ex.push_back(nd);
      tick();
    end
    bus.req_rdy_i[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nd = DW'($urandom);
      bus.in_dat_i[2] = nd;
      #1;
      if (bus.occ_o[2] !== OW'(2) || bus.req_dat_o[2] !== ex[0]) begin
        fails++;
        $display("FAIL pushpop_%0d: got occ=%0d dat=%h expected occ=2 dat=%h",
                 i, bus.occ_o[2], bus.req_dat_o[2], ex[0]);
      end
      tests++;
      tick();
      void'(ex.pop_front());
      ex.push_back(nd);
    end
    bus.in_vld_i[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus.req_dat_o[2] !== ex[0]) begin
        fails++;
        $display("FAIL pushpop_tail%0d: got %h expected %h", i, bus.req_dat_o[2], ex[0]);
      end
      tests++;
      tick();
      void'(ex.pop_front());
    end
    bus.req_rdy_i[2] = 1'b0;
    $display("[TB] push/pop across wrap ch2 done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      bus.in_vld_i = '1;
      for (int c = 0; c < N; c++) bus.in_dat_i[c] = DW'($urandom);
      tick();
    end
    flush = 1'b1;
    bus.in_vld_i = '1;
    bus.req_rdy_i = '1;
    for (int c = 0; c < N; c++) bus.in_dat_i[c] = 16'hDEAD;
    #1;
    if (bus.in_rdy_o !== '0) begin
      fails++; $display("FAIL flush_rdy: got %h expected 0", bus.in_rdy_o);
    end
    tests++;
    tick();
    flush = 1'b0;
    bus.in_vld_i = '0;
    bus.req_rdy_i = '0;
    #1;
    if (bus.occ_o !== '0 || bus.req_vld_o !== '0) begin
      fails++;
      $display("FAIL flush_clear: got occ=%h vld=%h expected 0", bus.occ_o, bus.req_vld_o);
    end
    tests++;
    bus.in_vld_i = '1;
    for (int c = 0; c < N; c++) bus.in_dat_i[c] = DW'(16'h5A00 + c);
    tick();
    bus.in_vld_i = '0;
    #1;
    for (int c = 0; c < N; c++) begin
      if (bus.req_vld_o[c] !== 1'b1 || bus.occ_o[c] !== OW'(1) ||
          bus.req_dat_o[c] !== DW'(16'h5A00 + c)) begin
        fails++;
        $display("FAIL flush_after%0d: got vld=%b occ=%0d dat=%h expected vld=1 occ=1 dat=%h",
                 c, bus.req_vld_o[c], bus.occ_o[c], bus.req_dat_o[c], 16'h5A00 + c);
      end
      tests++;
    end
    bus.req_rdy_i = '1;
    tick();
    bus.req_rdy_i = '0;
    $display("[TB] flush done");
  endtask

  task automatic test_random();
    logic [OW-1:0] eo;
    logic [WW-1:0] ew;
    bit            er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_vld_i  = N'($urandom);
      bus.req_rdy_i = N'($urandom) & N'($urandom);
      for (int c = 0; c < N; c++) bus.in_dat_i[c] = DW'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      #1;
      for (int c = 0; c < N; c++) begin
        eo = OW'(mq[c].size());
        ew = WW'(mage[c] >> SH);
        er = (mq[c].size() != D) && !flush;
        if (bus.occ_o[c] !== eo || bus.req_vld_o[c] !== (mq[c].size() != 0) ||
            bus.in_rdy_o[c] !== er || bus.req_wgt_o[c] !== ew ||
            (mq[c].size() != 0 && bus.req_dat_o[c] !== mq[c][0])) begin
          fails++;
          $display("FAIL rand_c%0d_ch%0d: got occ=%0d vld=%b rdy=%b wgt=%0d dat=%h expected occ=%0d rdy=%b wgt=%0d dat=%h",
                   cyc, c, bus.occ_o[c], bus.req_vld_o[c], bus.in_rdy_o[c], bus.req_wgt_o[c],
                   bus.req_dat_o[c], eo, er, ew, (mq[c].size() != 0) ? mq[c][0] : '0);
        end
        tests++;
      end
      tick();
    end
    flush = 1'b0;
    $display("[TB] random traffic done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.in_vld_i  = '1;
      bus.req_rdy_i = N'($urandom) & N'($urandom);
      for (int c = 0; c < N; c++) bus.in_dat_i[c] = DW'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_vld_i  = '0;
    bus.req_rdy_i = '0;
    #1;
    if (bus.req_vld_o !== '0 || bus.occ_o !== '0 || bus.in_rdy_o !== {N{1'b1}}) begin
      fails++;
      $display("FAIL reset_mid: got vld=%h occ=%h rdy=%h expected vld=0 occ=0 rdy=all ones",
               bus.req_vld_o, bus.occ_o, bus.in_rdy_o);
    end
    tests++;
    $display("[TB] reset mid-stream done");
  endtask

  initial begin
    bus.in_vld_i  = '0;
    bus.in_dat_i  = '0;
    bus.req_rdy_i = '0;
    for (int c = 0; c < N; c++) mage[c] = 0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_full_pop();
    test_aging();
    test_push_pop_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stl_req_queue.md
STL_REQ_QUEUE -- requirements
Module: stl_req_queue

Interface
REQ-001 Parameter REQ_N, default 8: number of independent requester channels (>=2).
REQ-002 Parameter DAT_W, default 16: payload width per entry.
REQ-003 Parameter DEPTH, default 4: entries per channel FIFO (power of 2, >=2).
REQ-004 Parameter WGT_W, default 2: urgency weight width per channel.
REQ-005 Parameter AGE_SH, default 2: age-to-weight shift; age counter width AGE_W = WGT_W+AGE_SH.
REQ-006 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-007 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all queued entries
- in_vld_i  in  REQ_N  per-channel push valid
- in_dat_i  in  REQ_N x DAT_W  per-channel push payload
- in_rdy_o  out  REQ_N  per-channel push ready
- req_vld_o  out  REQ_N  head-of-queue valid, to arbiter req_vld_i
- req_dat_o  out  REQ_N x DAT_W  head-of-queue payload, to arbiter req_dat_i
- req_wgt_o  out  REQ_N x WGT_W  age-based urgency, to arbiter req_wgt_i
- req_rdy_i  in  REQ_N  per-channel pop, from arbiter req_rdy_o
- occ_o  out  REQ_N x clog2(DEPTH+1)  per-channel occupancy

Function
REQ-008 Each channel SHALL be an independent circular FIFO with write pointer, read pointer, and occupancy count.
REQ-009 Push SHALL occur on in_vld_i[i] && in_rdy_o[i]; pop SHALL occur on req_vld_o[i] && req_rdy_i[i].
REQ-010 in_rdy_o[i] SHALL equal (occ[i] != DEPTH) && !flush_i; a full channel SHALL NOT accept a push even when a pop occurs in the same cycle.
REQ-011 req_vld_o[i] SHALL equal (occ[i] != 0); there is no bypass, so the push-to-req_vld_o latency is exactly 1 cycle.
REQ-012 req_dat_o[i] SHALL be the entry at the read pointer, held stable until popped.
REQ-013 Simultaneous push and pop on a channel SHALL leave occ unchanged and advance both pointers.
REQ-014 Pointers SHALL wrap modulo DEPTH.
REQ-015 occ_o SHALL be registered occupancy, in the range 0..DEPTH.
REQ-016 Per-channel age counter (AGE_W bits):
- cleared to 0 on pop, when the channel is empty, or on flush
- otherwise +1 each cycle while req_vld_o[i] && !req_rdy_i[i]
- saturates at all-ones, never wraps
REQ-017 req_wgt_o[i] SHALL be age[i] >> AGE_SH (upper WGT_W bits of the counter); it may rise while the head waits, and this SHALL be the only head-side field that changes while req_vld_o[i] is high.
REQ-018 After a pop, the next entry's age SHALL start at 0 in the following cycle.
REQ-019 flush_i SHALL zero all occ, pointers and ages on the next edge; a push or pop presented in a flush cycle SHALL have no effect on storage or state.
REQ-020 Channels SHALL have no cross-channel interaction apart from the shared flush_i.

Reset
REQ-021 On rst high at a clk edge, all pointers, occ and age counters SHALL clear to 0.
REQ-022 The first cycle after reset SHALL show req_vld_o=0, req_wgt_o=0, occ_o=0, and in_rdy_o all-ones if flush_i=0.
REQ-023 Storage arrays SHALL NOT require reset; req_dat_o is don't-care while req_vld_o=0.
REQ-024 rst asserted mid-traffic SHALL discard all entries identically to flush.

Verification
REQ-025 Fill/drain, ch0: push 0x11,0x22,0x33,0x44 with req_rdy_i=0 -> occ_o[0]=4, in_rdy_o[0]=0; then req_rdy_i=1 -> pops 0x11..0x44 in order, occ reaches 0, req_vld_o[0]=0.
REQ-026 Full with simultaneous pop, ch1 full: in_vld_i=1, req_rdy_i=1 -> push rejected, occ_o[1]=3 next cycle.
REQ-027 Aging, defaults: single entry held with req_rdy_i=0 -> req_wgt_o=0 for 4 cycles, 1 after 4 stall cycles, 3 and saturated after 15; pop -> next head weight 0.
REQ-028 Push-pop at occ=2, ch2: push and pop in the same cycle -> occ stays 2 and FIFO order is preserved across pointer wrap (>=6 entries).
REQ-029 Flush with all channels partially full: assert flush_i with in_vld_i all-ones -> next cycle occ_o all 0, req_vld_o=0, and no flush-cycle data ever emerges.
REQ-030 Reset mid-stream: rst during active traffic -> next cycle req_vld_o=0, occ_o=0, in_rdy_o all-ones.
